// File: rtl/subckt_vector_sequencer_pkg.sv
// Shared types, defaults and helpers for the subcircuit vector sequencer.
package subckt_seq_pkg;

  // Sequencer FSM states, fixed 3-bit encoding.
  typedef enum logic [2:0] {
    ST_FLUSH   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_APPLY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_VEC_W   = 6;
  localparam int DEF_LATENCY = 3;
  localparam int DEF_CNT_W   = 16;

  // Ceiling log2, never below 1 so index/counter vectors always have a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    while ((32'd1 << r) < v) begin
      r = r + 32'd1;
    end
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/subckt_vector_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter
  import subckt_seq_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  int                 p;
  logic               found;
  logic [IDX_W-1:0]   pos;

  // Search requesters in index order starting at the pointer, wrapping once.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    p     = 0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = int'(ptr_i) + k;
      if (p >= NUM_REQ) begin
        p = p - NUM_REQ;
      end else begin
        p = p;
      end
      pos = IDX_W'(p);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/subckt_vector_sequencer.sv
// Shares one registered NUT subcircuit among several pattern sources:
// round-robin grant, hold vector LATENCY+1 cycles, capture, compare, respond.
module subckt_vector_sequencer
  import subckt_seq_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int VEC_W   = DEF_VEC_W,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     I1470_clk,
  input  logic                     I1477_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*VEC_W-1:0] req_vec,
  input  logic [NUM_REQ-1:0]       req_exp,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic                     rsp_bit,
  output logic                     rsp_mis,
  output logic [VEC_W-1:0]         nut_in,
  output logic                     nut_rst,
  input  logic                     nut_out,
  output logic [CNT_W-1:0]         mis_cnt,
  output logic                     busy
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CTR_W = clog2(LATENCY + 1);

  state_e               state_q, state_d;
  logic [CTR_W-1:0]     ctr_q, ctr_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic                 exp_q, exp_d;
  logic [CNT_W-1:0]     mis_cnt_q, mis_cnt_d;
  logic                 rsp_bit_q, rsp_bit_d;
  logic                 rsp_mis_q, rsp_mis_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [VEC_W-1:0]     nut_in_q, nut_in_d;
  logic                 nut_rst_q, nut_rst_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic [VEC_W-1:0]     vec_sel;
  logic                 exp_sel;
  logic                 start_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign start_s = (state_q == ST_IDLE) && (|req);

  // Select the winning source's vector and expected bit.
  always_comb begin
    vec_sel = '0;
    exp_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        vec_sel = req_vec[i*VEC_W +: VEC_W];
        exp_sel = req_exp[i];
      end else begin
        vec_sel = vec_sel;
      end
    end
  end

  // State register; reset always restarts from FLUSH.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      state_q <= ST_FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; one counter times both FLUSH and APPLY.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      ST_FLUSH: begin
        if (ctr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          ctr_d = ctr_q - CTR_W'(1);
        end
      end
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_APPLY;
          ctr_d   = CTR_W'(LATENCY);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (ctr_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          ctr_d = ctr_q - CTR_W'(1);
        end
      end
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default: begin
        state_d = ST_FLUSH;
        ctr_d   = CTR_W'(LATENCY - 1);
      end
    endcase
  end

  // Datapath next values: grant latches, capture/compare, pointer advance.
  always_comb begin
    idx_d     = idx_q;
    vec_d     = vec_q;
    exp_d     = exp_q;
    ptr_d     = ptr_q;
    rsp_bit_d = rsp_bit_q;
    rsp_mis_d = rsp_mis_q;
    mis_cnt_d = mis_cnt_q;
    if (start_s) begin
      idx_d = arb_idx;
      vec_d = vec_sel;
      exp_d = exp_sel;
    end else begin
      idx_d = idx_q;
    end
    if (state_q == ST_CAPTURE) begin
      rsp_bit_d = nut_out;
      rsp_mis_d = nut_out ^ exp_q;
      if ((nut_out ^ exp_q) && (mis_cnt_q != {CNT_W{1'b1}})) begin
        mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end else begin
        mis_cnt_d = mis_cnt_q;
      end
    end else begin
      rsp_bit_d = rsp_bit_q;
    end
    if (state_q == ST_RESP) begin
      ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Output next values, decoded from the upcoming state so outputs are registered.
  always_comb begin
    gnt_d       = '0;
    rsp_valid_d = '0;
    nut_in_d    = '0;
    nut_rst_d   = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_FLUSH: nut_rst_d = 1'b1;
      ST_IDLE:  gnt_d = '0;
      ST_APPLY: begin
        gnt_d    = start_s ? arb_gnt : gnt_q;
        nut_in_d = vec_d;
      end
      ST_CAPTURE: gnt_d = gnt_q;
      ST_RESP: begin
        gnt_d       = gnt_q;
        rsp_valid_d = gnt_q;
      end
      default: nut_rst_d = 1'b1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      ctr_q       <= CTR_W'(LATENCY - 1);
      ptr_q       <= '0;
      idx_q       <= '0;
      vec_q       <= '0;
      exp_q       <= 1'b0;
      mis_cnt_q   <= '0;
      rsp_bit_q   <= 1'b0;
      rsp_mis_q   <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      nut_in_q    <= '0;
      nut_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      exp_q       <= exp_d;
      mis_cnt_q   <= mis_cnt_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_mis_q   <= rsp_mis_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      nut_in_q    <= nut_in_d;
      nut_rst_q   <= nut_rst_d;
      busy_q      <= busy_d;
    end
  end

  // In IDLE the arbiter's pick is shown in the decision cycle itself.
  assign gnt       = (state_q == ST_IDLE) ? arb_gnt : gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bit   = rsp_bit_q;
  assign rsp_mis   = rsp_mis_q;
  assign nut_in    = nut_in_q;
  assign nut_rst   = nut_rst_q;
  assign mis_cnt   = mis_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_subckt_vector_sequencer.sv
// Directed bench for subckt_vector_sequencer with a parity NUT model of depth 3.
module tb_subckt_vector_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [23:0] req_vec;
  logic [3:0]  req_exp;
  logic [3:0]  gnt, gnt2, rsp_valid, rsp_valid2;
  logic        rsp_bit, rsp_bit2, rsp_mis, rsp_mis2;
  logic [5:0]  nut_in, nut_in2;
  logic        nut_rst, nut_rst2, nut_out, nut_out2;
  logic [15:0] mis_cnt;
  logic [1:0]  mis_cnt2;
  logic        busy, busy2;
  logic [2:0]  pipe, pipe2;
  int          n_checks;
  int          n_errors;
  int          sat_tab [5];

  subckt_vector_sequencer #(.NUM_REQ(4), .VEC_W(6), .LATENCY(3), .CNT_W(16)) dut (
    .I1470_clk(clk), .I1477_rst(rst), .req(req), .req_vec(req_vec), .req_exp(req_exp),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .rsp_mis(rsp_mis),
    .nut_in(nut_in), .nut_rst(nut_rst), .nut_out(nut_out), .mis_cnt(mis_cnt), .busy(busy)
  );

  subckt_vector_sequencer #(.NUM_REQ(4), .VEC_W(6), .LATENCY(3), .CNT_W(2)) dut2 (
    .I1470_clk(clk), .I1477_rst(rst), .req(req), .req_vec(req_vec), .req_exp(req_exp),
    .gnt(gnt2), .rsp_valid(rsp_valid2), .rsp_bit(rsp_bit2), .rsp_mis(rsp_mis2),
    .nut_in(nut_in2), .nut_rst(nut_rst2), .nut_out(nut_out2), .mis_cnt(mis_cnt2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NUT models: parity of the input vector through three flops, cleared by nut_rst.
  always @(posedge clk or posedge rst) begin
    if (rst) pipe <= 3'b000;
    else if (nut_rst) pipe <= 3'b000;
    else pipe <= {pipe[1:0], ^nut_in};
  end
  always @(posedge clk or posedge rst) begin
    if (rst) pipe2 <= 3'b000;
    else if (nut_rst2) pipe2 <= 3'b000;
    else pipe2 <= {pipe2[1:0], ^nut_in2};
  end
  assign nut_out  = pipe[2];
  assign nut_out2 = pipe2[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Source table: vec0=2A(par 1) vec1=03(par 0) vec2=07(par 1) vec3=00(par 0); exp = 0,0,1,1.
  task automatic load_table();
    req_vec = {6'h00, 6'h07, 6'h03, 6'h2A};
    req_exp = 4'b1100;
  endtask

  // Holds reset two cycles, releases it, and checks the three-cycle FLUSH.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_nut_rst", nut_rst, 1);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_nut_in", nut_in, 0);
    check_eq("rst_mis_cnt", mis_cnt, 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("flush_nut_rst", nut_rst, (i < 3) ? 1 : 0);
      check_eq("flush_busy", busy, (i < 3) ? 1 : 0);
      check_eq("flush_rsp_valid", rsp_valid, 0);
      if (i < 3) check_eq("flush_gnt", gnt, 0);
    end
  endtask

  // Waits for a grant in IDLE, then checks one full transaction cycle by cycle.
  task automatic expect_txn(input int src, input logic [5:0] v, input logic bit_e,
                            input logic mis_e, input int cnt_e, input int cnt2_e,
                            input bit perturb);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << src;
    #1;
    for (n = 0; n < 40 && gnt == 4'b0000; n++) begin
      @(negedge clk);
      #1;
    end
    if (gnt == 4'b0000) begin
      check_eq("gnt_timeout", 0, 1);
      return;
    end
    check_eq("gnt_pick", gnt, oh);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #1;
      if (perturb && c == 2) req_vec[src*6 +: 6] = 6'h15;
      if (perturb && c == 3) req[src] = 1'b0;
      check_eq("gnt_hold", gnt, oh);
      if (c <= 4) begin
        check_eq("apply_nut_in", nut_in, v);
        check_eq("apply_rsp_valid", rsp_valid, 0);
        check_eq("apply_busy", busy, 1);
      end else if (c == 5) begin
        check_eq("capture_nut_in", nut_in, 0);
        check_eq("capture_rsp_valid", rsp_valid, 0);
      end else begin
        check_eq("resp_valid", rsp_valid, oh);
        check_eq("resp_bit", rsp_bit, bit_e);
        check_eq("resp_mis", rsp_mis, mis_e);
        check_eq("mis_cnt", mis_cnt, cnt_e);
        check_eq("resp_valid_c2", rsp_valid2, oh);
        check_eq("resp_bit_c2", rsp_bit2, bit_e);
        check_eq("resp_mis_c2", rsp_mis2, mis_e);
        check_eq("gnt_c2", gnt2, oh);
        check_eq("mis_cnt_c2", mis_cnt2, cnt2_e);
      end
    end
    @(negedge clk);
    #1;
    check_eq("post_rsp_valid", rsp_valid, 0);
    check_eq("post_busy", busy, 0);
    check_eq("post_busy_c2", busy2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    sat_tab  = '{1, 2, 3, 3, 3};
    rst      = 1'b1;
    req      = 4'b0000;
    load_table();

    // Reset and FLUSH with no requests.
    do_reset();
    check_eq("idle_gnt", gnt, 0);
    check_eq("idle_mis_cnt", mis_cnt, 0);

    // Single transaction; vector changes and req drops mid-flight are ignored.
    req = 4'b0001;
    expect_txn(0, 6'h2A, 1'b1, 1'b1, 1, 1, 1'b1);
    load_table();
    check_eq("drop_req", req, 0);

    // Pointer to 3 via source 2, then 1001 wraps 3 -> 0.
    req = 4'b0100;
    expect_txn(2, 6'h07, 1'b1, 1'b0, 1, 1, 1'b0);
    req = 4'b1001;
    expect_txn(3, 6'h00, 1'b0, 1'b1, 2, 2, 1'b0);
    expect_txn(0, 6'h2A, 1'b1, 1'b1, 3, 3, 1'b0);
    req = 4'b0000;

    // Reset in the middle of APPLY, then FLUSH replay and re-grant.
    @(negedge clk);
    req = 4'b0010;
    #1;
    check_eq("d_gnt", gnt, 4'b0010);
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    check_eq("d_apply_nut_in", nut_in, 6'h03);
    rst = 1'b1;
    #1;
    check_eq("d_rst_gnt", gnt, 0);
    check_eq("d_rst_nut_in", nut_in, 0);
    check_eq("d_rst_rsp_valid", rsp_valid, 0);
    check_eq("d_rst_nut_rst", nut_rst, 1);
    check_eq("d_rst_mis_cnt", mis_cnt, 0);
    do_reset();
    expect_txn(1, 6'h03, 1'b0, 1'b0, 0, 0, 1'b0);
    req = 4'b0000;

    // All four requesting: order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    expect_txn(0, 6'h2A, 1'b1, 1'b1, 1, 1, 1'b0);
    expect_txn(1, 6'h03, 1'b0, 1'b0, 1, 1, 1'b0);
    expect_txn(2, 6'h07, 1'b1, 1'b0, 1, 1, 1'b0);
    expect_txn(3, 6'h00, 1'b0, 1'b1, 2, 2, 1'b0);
    expect_txn(0, 6'h2A, 1'b1, 1'b1, 3, 3, 1'b0);
    req = 4'b0000;

    // Five forced mismatches: 16-bit counter 1..5, 2-bit counter saturates.
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      expect_txn(0, 6'h2A, 1'b1, 1'b1, k + 1, sat_tab[k], 1'b0);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    check_eq("final_mis_cnt_c2", mis_cnt2, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
